// File: rtl/olive_std_core_boot_loader.sv
// Byte-stream to Avalon-MM boot RAM loader: packs little-endian words and writes them from address 0.
// Define OLIVE_BOOT_LOADER_VERIFY_EN to add a checksum read-back pass after the last write.
module olive_std_core_boot_loader #(
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RD, CHK, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FIN} state_t;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] count;
  logic [1:0]      byte_idx;
  logic [23:0]     partial;

  logic            len_ok;
  logic [ADDR_W:0] count_inc;

  assign len_ok    = (len_words != '0) && (len_words <= DEPTH_L);
  assign count_inc = count + ONE_L;

`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
  logic [31:0] wsum;
  logic [31:0] rsum;
  logic [31:0] rsum_next;
  logic        last_read;

  assign rsum_next = rsum + m_readdata;
  assign last_read = (({1'b0, m_address} + ONE_L) == len_q);
`else
  logic unused_readdata;
  assign unused_readdata = ^m_readdata;
  assign m_read = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      len_q        <= '0;
      count        <= '0;
      byte_idx     <= '0;
      partial      <= '0;
      in_ready     <= 1'b0;
      m_address    <= '0;
      m_byteenable <= 4'h0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
      m_read       <= 1'b0;
      wsum         <= '0;
      rsum         <= '0;
`endif
    end else begin
      // done is a single-cycle pulse raised only on the transition into FIN
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state     <= COLLECT;
              len_q     <= len_words;
              count     <= '0;
              byte_idx  <= '0;
              m_address <= '0;
              error     <= 1'b0;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
              wsum      <= '0;
              rsum      <= '0;
`endif
            end else begin
              state <= FIN;
              error <= 1'b1;
              done  <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (in_valid) begin
            if (byte_idx == 2'd3) begin
              m_writedata  <= {in_data, partial};
              byte_idx     <= '0;
              in_ready     <= 1'b0;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_byteenable <= 4'hF;
              state        <= WRITE;
            end else begin
              partial[byte_idx*8 +: 8] <= in_data;
              byte_idx                 <= byte_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          if (!m_waitrequest) begin
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_byteenable <= 4'h0;
            count        <= count_inc;
`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
            wsum         <= wsum + m_writedata;
`endif
            if (count_inc == len_q) begin
`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
              state        <= RD;
              m_address    <= '0;
              m_chipselect <= 1'b1;
              m_read       <= 1'b1;
`else
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              m_address <= m_address + ONE_A;
              in_ready  <= 1'b1;
              state     <= COLLECT;
            end
          end
        end

`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
        RD: begin
          if (!m_waitrequest) begin
            m_chipselect <= 1'b0;
            m_read       <= 1'b0;
            state        <= CHK;
          end
        end

        CHK: begin
          // read data is valid exactly one cycle after the accepted read
          rsum <= rsum_next;
          if (last_read) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= (rsum_next != wsum);
          end else begin
            m_address    <= m_address + ONE_A;
            m_chipselect <= 1'b1;
            m_read       <= 1'b1;
            state        <= RD;
          end
        end
`endif

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_olive_std_core_boot_loader.sv
// Directed, table-driven bench for olive_std_core_boot_loader with an inline zero-latency RAM/slave model.
`timescale 1ns/1ps
module tb_olive_std_core_boot_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len_words = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_read;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  olive_std_core_boot_loader #(.DEPTH_WORDS(512), .ADDR_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len_words(len_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          n_writes, n_reads, lat, stall_cnt, stall_bad, ir_viol, be_bad, wcycles, rd_bad;
  logic [31:0] wr_data [512];
  logic [8:0]  wr_addr [512];
  logic [31:0] ram [512];
  logic        err_done, err_after, done_after, busy1, busy_after;

  typedef struct {
    logic [9:0]  len;
    logic [7:0]  step;
    logic        exp_err;
    int          exp_writes;
    int          exp_lat;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [8:0]  exp_last_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [7:0] step, input int idx);
    logic [31:0] p;
    p = step * (idx + 1);
    return p[7:0];
  endfunction

  // Extra cycles spent in the read-back pass (two per word) when it is built in.
  function automatic int rd_extra(input int words);
`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
    return 2 * words;
`else
    return 0 * words;
`endif
  endfunction

  // One complete load: drives the byte stream, acts as the Avalon slave, records bus activity.
  task automatic run_load(input logic [9:0] len, input logic [7:0] step, input int wait_first,
                          input bit restart, input bit corrupt);
    int          idx, nbytes, wl;
    bit          have_hold;
    logic [8:0]  hold_a;
    logic [31:0] hold_d;
    nbytes = (len >= 10'd1 && len <= 10'd512) ? 4 * int'(len) : 0;
    n_writes = 0; n_reads = 0; lat = -1; stall_cnt = 0; stall_bad = 0; ir_viol = 0;
    be_bad = 0; wcycles = 0; rd_bad = 0; busy1 = 1'b0; err_done = 1'b0;
    wl = wait_first; idx = 0; have_hold = 1'b0; hold_a = '0; hold_d = '0;
    @(negedge clk);
    start = 1'b1; len_words = len; in_valid = 1'b0;
    for (int cyc = 1; cyc <= 6000 && lat < 0; cyc++) begin
      @(negedge clk);
      start = restart && (cyc == 3);
      len_words = (restart && cyc == 3) ? 10'd0 : len;
      if (cyc == 1) busy1 = busy;
      if (m_chipselect && m_write) begin
        wcycles++;
        if (!have_hold) begin
          have_hold = 1'b1; hold_a = m_address; hold_d = m_writedata;
        end else if (m_address !== hold_a || m_writedata !== hold_d) begin
          stall_bad++;
        end
        if (in_ready) ir_viol++;
        if (n_writes == 0 && wl > 0) begin
          m_waitrequest = 1'b1; wl--; stall_cnt++;
        end else begin
          m_waitrequest = 1'b0;
        end
      end else begin
        m_waitrequest = 1'b0;
      end
      if (m_chipselect && m_write && !m_waitrequest) begin
        wr_addr[n_writes] = m_address;
        wr_data[n_writes] = m_writedata;
        if (m_byteenable !== 4'hF) be_bad++;
        ram[m_address] = m_writedata;
        n_writes++;
        have_hold = 1'b0;
      end
      if (m_chipselect && m_read && !m_waitrequest) begin
        if (m_address !== 9'(n_reads)) rd_bad++;
        m_readdata = ram[m_address] ^ ((corrupt && m_address == 9'd2) ? 32'd1 : 32'd0);
        n_reads++;
      end
      if (done) begin
        lat = cyc; err_done = error;
      end
      in_valid = (idx < nbytes);
      in_data  = byte_of(step, idx);
      if (in_valid && in_ready) idx++;
    end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    err_after = error; done_after = done; busy_after = busy;
    if (lat < 0) begin
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    int         idx;
    int         pre_writes;
    logic [8:0] pre_addr;
    vec_t       v;

    vecs[0] = '{10'd2,    8'h11, 1'b0, 2,   11,   32'h44332211, 32'h88776655, 9'd1};
    vecs[1] = '{10'd0,    8'h11, 1'b1, 0,   1,    32'h0,        32'h0,        9'd0};
    vecs[2] = '{10'd513,  8'h11, 1'b1, 0,   1,    32'h0,        32'h0,        9'd0};
    vecs[3] = '{10'd1,    8'h01, 1'b0, 1,   6,    32'h04030201, 32'h04030201, 9'd0};
    vecs[4] = '{10'd3,    8'h10, 1'b0, 3,   16,   32'h40302010, 32'hC0B0A090, 9'd2};
    vecs[5] = '{10'd512,  8'h01, 1'b0, 512, 2561, 32'h04030201, 32'h00FFFEFD, 9'd511};
    vecs[6] = '{10'd1023, 8'h01, 1'b1, 0,   1,    32'h0,        32'h0,        9'd0};

    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset ctl", {26'd0, m_chipselect, m_write, m_read, busy, done, error}, 32'd0);
    check("reset addr/be", {19'd0, m_address, m_byteenable}, 32'd0);
    check("reset wdata", m_writedata, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_load(v.len, v.step, 0, 1'b0, 1'b0);
      $display("[TB] vec %0d len=%0d writes=%0d reads=%0d lat=%0d error=%0b",
               i, v.len, n_writes, n_reads, lat, err_done);
      check($sformatf("v%0d latency", i), 32'(lat),
            32'(v.exp_lat + (v.exp_writes > 0 ? rd_extra(v.exp_writes) : 0)));
      check($sformatf("v%0d error", i), {31'd0, err_done}, {31'd0, v.exp_err});
      check($sformatf("v%0d error held", i), {31'd0, err_after}, {31'd0, v.exp_err});
      check($sformatf("v%0d done pulse", i), {31'd0, done_after}, 32'd0);
      check($sformatf("v%0d busy", i), {30'd0, busy1, busy_after}, {30'd0, !v.exp_err, 1'b0});
      check($sformatf("v%0d writes", i), 32'(n_writes), 32'(v.exp_writes));
      check($sformatf("v%0d reads", i), 32'(n_reads), 32'(rd_extra(v.exp_writes) / 2));
      check($sformatf("v%0d be/ready/rdaddr", i), 32'(be_bad + ir_viol + rd_bad), 32'd0);
      if (v.exp_writes > 0 && n_writes == v.exp_writes) begin
        check($sformatf("v%0d first", i), wr_data[0], v.exp_first);
        check($sformatf("v%0d first addr", i), {23'd0, wr_addr[0]}, 32'd0);
        check($sformatf("v%0d last", i), wr_data[n_writes-1], v.exp_last);
        check($sformatf("v%0d last addr", i), {23'd0, wr_addr[n_writes-1]}, {23'd0, v.exp_last_addr});
      end
    end

    // Stalled first write: held for three wait cycles plus the accepting cycle.
    run_load(10'd1, 8'h07, 3, 1'b0, 1'b0);
    $display("[TB] stall len=1 writes=%0d wcycles=%0d lat=%0d", n_writes, wcycles, lat);
    check("stall writes", 32'(n_writes), 32'd1);
    check("stall data", wr_data[0], 32'h1C150E07);
    check("stall cycles", 32'(stall_cnt), 32'd3);
    check("stall write cycles", 32'(wcycles), 32'd4);
    check("stall stable", 32'(stall_bad), 32'd0);
    check("stall in_ready", 32'(ir_viol), 32'd0);
    check("stall latency", 32'(lat), 32'(9 + rd_extra(1)));
    check("stall error", {31'd0, err_done}, 32'd0);

    // A bad-length start while busy must be ignored.
    run_load(10'd2, 8'h11, 0, 1'b1, 1'b0);
    $display("[TB] restart-while-busy writes=%0d lat=%0d error=%0b", n_writes, lat, err_done);
    check("busy start latency", 32'(lat), 32'(11 + rd_extra(2)));
    check("busy start error", {31'd0, err_done}, 32'd0);
    check("busy start writes", 32'(n_writes), 32'd2);

    // Reset in the middle of the second word of a 4-word load.
    @(negedge clk);
    start = 1'b1; len_words = 10'd4; idx = 0; pre_writes = 0;
    for (int cyc = 0; cyc < 100 && idx < 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      m_waitrequest = 1'b0;
      if (m_chipselect && m_write) pre_writes++;
      in_valid = (idx < 6);
      in_data  = byte_of(8'h03, idx);
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    pre_addr = m_address;
    check("pre-reset writes", 32'(pre_writes), 32'd1);
    check("pre-reset addr", {23'd0, pre_addr}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] async reset mid-load: ready=%0b busy=%0b addr=%0d", in_ready, busy, m_address);
    check("abort in_ready", {31'd0, in_ready}, 32'd0);
    check("abort ctl", {26'd0, m_chipselect, m_write, m_read, busy, done, error}, 32'd0);
    check("abort addr/be", {19'd0, m_address, m_byteenable}, 32'd0);
    check("abort wdata", m_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_load(10'd1, 8'h05, 0, 1'b0, 1'b0);
    $display("[TB] post-reset len=1 writes=%0d addr=%0d data=%h", n_writes, wr_addr[0], wr_data[0]);
    check("post-reset writes", 32'(n_writes), 32'd1);
    check("post-reset addr", {23'd0, wr_addr[0]}, 32'd0);
    check("post-reset data", wr_data[0], 32'h140F0A05);
    check("post-reset latency", 32'(lat), 32'(6 + rd_extra(1)));

`ifdef OLIVE_BOOT_LOADER_VERIFY_EN
    run_load(10'd3, 8'h21, 0, 1'b0, 1'b1);
    $display("[TB] verify corrupt reads=%0d error=%0b", n_reads, err_done);
    check("verify corrupt reads", 32'(n_reads), 32'd3);
    check("verify corrupt error", {31'd0, err_done}, 32'd1);
    run_load(10'd3, 8'h21, 0, 1'b0, 1'b0);
    $display("[TB] verify clean reads=%0d error=%0b", n_reads, err_done);
    check("verify clean reads", 32'(n_reads), 32'd3);
    check("verify clean error", {31'd0, err_done}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/olive_std_core_boot_loader.md
OLIVE_STD_CORE_BOOT_LOADER -- requirements
Module: olive_std_core_boot_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512: boot RAM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 9: word-address width, log2(DEPTH_WORDS).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle load request, sampled only in IDLE.
REQ-006 len_words  in  ADDR_W+1  number of words to load, captured on accepted start.
REQ-007 in_data  in  8  byte-stream data.
REQ-008 in_valid  in  1  byte-stream valid.
REQ-009 in_ready  out  1  byte-stream ready; byte transfers when in_valid & in_ready.
REQ-010 m_address  out  ADDR_W  Avalon-MM word address.
REQ-011 m_byteenable  out  4  Avalon-MM byte enables.
REQ-012 m_chipselect  out  1  Avalon-MM chipselect.
REQ-013 m_write  out  1  Avalon-MM write.
REQ-014 m_writedata  out  32  Avalon-MM write data.
REQ-015 m_read  out  1  Avalon-MM read (verify build only).
REQ-016 m_readdata  in  32  Avalon-MM read data, valid exactly 1 cycle after an accepted read.
REQ-017 m_waitrequest  in  1  Avalon-MM stall; tie 0 for the fixed-latency boot RAM.
REQ-018 busy  out  1  high from accepted start until done.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 error  out  1  sticky status of last load; cleared on next accepted start.

Function
REQ-021 SHALL implement FSM IDLE, COLLECT, WRITE, RD, CHK, FIN; RD/CHK exist only in the verify build.
REQ-022 IDLE: start with 1 <= len_words <= DEPTH_WORDS -> COLLECT, address 0, error cleared; any other len_words -> FIN with error=1 and no bus cycles.
REQ-023 start while busy SHALL be ignored.
REQ-024 COLLECT: in_ready=1; bytes pack little-endian (byte k -> bits 8k+7:8k); fourth byte -> WRITE on next cycle.
REQ-025 in_ready SHALL be 0 in every state except COLLECT.
REQ-026 WRITE: m_chipselect=m_write=1, m_byteenable=4'hF, address/data held stable while m_waitrequest=1.
REQ-027 Write accepted (m_waitrequest=0): word count increments; if count==len_words -> RD (verify) or FIN; else address+1 -> COLLECT.
REQ-028 Minimum throughput with zero wait: one word per 5 cycles (4 collect + 1 write).
REQ-029 Address SHALL never wrap; last written address is len_words-1.
REQ-030 FIN: done=1 for one cycle, busy=0, -> IDLE; error retains value until next accepted start.
REQ-031 With m_waitrequest=0, done SHALL assert exactly 1 cycle after the last write is accepted (non-verify build).

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE; in_ready, m_chipselect, m_write, m_read, busy, done, error=0; m_address, m_writedata, m_byteenable=0; partial byte assembly discarded.
REQ-033 Reset mid-load SHALL abort without a further bus cycle; RAM contents already written remain.

Configuration
REQ-034 Macro OLIVE_BOOT_LOADER_VERIFY_EN defined: 32-bit modulo-2^32 sum of written words accumulated; after last write, addresses 0..len_words-1 read back (RD: m_chipselect=m_read=1, held while m_waitrequest; CHK: sample m_readdata, add); mismatch of sums -> error=1 at FIN.
REQ-035 Macro undefined: m_read tied 0, no RD/CHK states or checksum logic; error only from invalid len_words.

Verification
REQ-036 len_words=2, bytes 11 22 33 44 55 66 77 88, waitrequest=0 -> writes addr0=32'h44332211, addr1=32'h88776655, be=4'hF, done pulse, error=0.
REQ-037 len_words=0 and len_words=513 -> done 1 cycle after start, error=1, no m_write/m_read.
REQ-038 m_waitrequest high 3 cycles on first write -> address/data stable 4 cycles, in_ready=0 throughout, single accepted write.
REQ-039 reset_n low after 6 bytes of len_words=4 -> all outputs 0 asynchronously; next load of 1 word writes addr0 only.
REQ-040 VERIFY_EN, len_words=3, RAM model corrupts addr2 by XOR 1 -> 3 reads issued after writes, error=1 at done; uncorrupted -> error=0.
